// File: rtl/load_store_unit.sv
// Memory-phase unit for RV32I loads and stores. It turns byte, halfword and word
// accesses into word-aligned req/ack bus transfers and returns extended load data.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_load,
    input  logic        start_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [1:0]  addr_lo_reg, addr_lo_next;
    logic        is_store_reg, is_store_next;

    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        fault_reg, fault_next;
    logic [31:0] load_data_reg, load_data_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;

    logic        start;
    logic        misaligned;
    logic        illegal;
    logic        timeout_hit;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] extracted;

    assign start       = start_store | start_load;
    assign misaligned  = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                         ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    // 011/110/111 never decode; unsigned variants only make sense for loads
    assign illegal     = (funct3 == 3'b011) || (funct3[2] && funct3[1]) ||
                         (start_store && funct3[2]);
    assign timeout_hit = (count_reg == TIMEOUT_LAST);

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                lane_strb  = 4'b0001 << addr[1:0];
                lane_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                lane_strb  = 4'b0011 << {addr[1], 1'b0};
                lane_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = mem_rdata >> {addr_lo_reg, 3'b000};

    always_comb begin
        extracted = mem_rdata;
        case (funct3_reg)
            F3_B:    extracted = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   extracted = {24'h0, shifted[7:0]};
            F3_H:    extracted = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   extracted = {16'h0, shifted[15:0]};
            default: extracted = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (misaligned || illegal) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: computes the next value of every registered output
    always_comb begin
        count_next     = count_reg;
        funct3_next    = funct3_reg;
        addr_lo_next   = addr_lo_reg;
        is_store_next  = is_store_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        fault_next     = 1'b0;
        load_data_next = load_data_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wstrb_next = mem_wstrb_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    funct3_next   = funct3;
                    addr_lo_next  = addr[1:0];
                    is_store_next = start_store;
                    if (misaligned || illegal) begin
                        done_next  = 1'b1;
                        fault_next = 1'b1;
                    end else begin
                        busy_next      = 1'b1;
                        mem_req_next   = 1'b1;
                        mem_we_next    = start_store;
                        mem_addr_next  = {addr[31:2], 2'b00};
                        mem_wstrb_next = start_store ? lane_strb : 4'b0000;
                        mem_wdata_next = lane_wdata;
                        count_next     = 8'd0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack || timeout_hit) begin
                    busy_next    = 1'b0;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    done_next    = 1'b1;
                    fault_next   = !mem_ack;
                    if (mem_ack && !is_store_reg) begin
                        load_data_next = extracted;
                    end
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= 8'd0;
            funct3_reg    <= 3'd0;
            addr_lo_reg   <= 2'd0;
            is_store_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            load_data_reg <= 32'd0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wstrb_reg <= 4'd0;
            mem_wdata_reg <= 32'd0;
        end else begin
            count_reg     <= count_next;
            funct3_reg    <= funct3_next;
            addr_lo_reg   <= addr_lo_next;
            is_store_reg  <= is_store_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            fault_reg     <= fault_next;
            load_data_reg <= load_data_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wstrb_reg <= mem_wstrb_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign fault     = fault_reg;
    assign load_data = load_data_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs change and outputs are sampled on the
// falling edge, so every check sees the state left by the preceding rising edge.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start_load;
    logic        start_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;
    int req_cycles;
    int done_count;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .start_store(start_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start_load = 1'b0; start_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;

        // Reset values
        step();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_ldata", load_data, 32'h0);
        rst = 1'b0;
        step();
        $display("reset released, outputs idle");

        // SB at 0x103, ack after two wait cycles
        start_store = 1'b1; funct3 = 3'b000; addr = 32'h103; store_data = 32'h0000_00A5;
        step();
        start_store = 1'b0;
        chk("sb_req", {31'h0, mem_req}, 32'h1);
        chk("sb_busy", {31'h0, busy}, 32'h1);
        chk("sb_we", {31'h0, mem_we}, 32'h1);
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_wstrb", {28'h0, mem_wstrb}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        step();
        chk("sb_req_w1", {31'h0, mem_req}, 32'h1);
        step();
        chk("sb_req_w2", {31'h0, mem_req}, 32'h1);
        chk("sb_done_early", {31'h0, done}, 32'h0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sb_done", {31'h0, done}, 32'h1);
        chk("sb_fault", {31'h0, fault}, 32'h0);
        chk("sb_req_drop", {31'h0, mem_req}, 32'h0);
        chk("sb_busy_drop", {31'h0, busy}, 32'h0);
        step();
        chk("sb_done_pulse", {31'h0, done}, 32'h0);
        $display("SB 0x103 data=0xa5 -> done");

        // LB at 0x202, zero-wait ack
        start_load = 1'b1; funct3 = 3'b000; addr = 32'h202;
        step();
        start_load = 1'b0;
        chk("lb_req", {31'h0, mem_req}, 32'h1);
        chk("lb_we", {31'h0, mem_we}, 32'h0);
        chk("lb_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("lb_addr", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'h0080_FF00;
        step();
        mem_ack = 1'b0;
        chk("lb_done", {31'h0, done}, 32'h1);
        chk("lb_fault", {31'h0, fault}, 32'h0);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        step();
        chk("lb_data_hold", load_data, 32'hFFFF_FF80);
        $display("LB 0x202 -> load_data=%h", load_data);

        // LBU at 0x202
        start_load = 1'b1; funct3 = 3'b100; addr = 32'h202;
        step();
        start_load = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("lbu_done", {31'h0, done}, 32'h1);
        chk("lbu_data", load_data, 32'h0000_0080);
        step();
        $display("LBU 0x202 -> load_data=%h", load_data);

        // Misaligned LH at 0x201
        start_load = 1'b1; funct3 = 3'b001; addr = 32'h201;
        step();
        start_load = 1'b0;
        chk("lh_mis_done", {31'h0, done}, 32'h1);
        chk("lh_mis_fault", {31'h0, fault}, 32'h1);
        chk("lh_mis_req", {31'h0, mem_req}, 32'h0);
        chk("lh_mis_busy", {31'h0, busy}, 32'h0);
        step();
        chk("lh_mis_pulse", {31'h0, done}, 32'h0);
        chk("lh_mis_req2", {31'h0, mem_req}, 32'h0);
        $display("LH 0x201 -> misaligned fault");

        // Misaligned SW at 0x302
        start_store = 1'b1; funct3 = 3'b010; addr = 32'h302; store_data = 32'h1111_2222;
        step();
        start_store = 1'b0;
        chk("sw_mis_done", {31'h0, done}, 32'h1);
        chk("sw_mis_fault", {31'h0, fault}, 32'h1);
        chk("sw_mis_req", {31'h0, mem_req}, 32'h0);
        step();
        $display("SW 0x302 -> misaligned fault");

        // Illegal store funct3 (SBU)
        start_store = 1'b1; funct3 = 3'b100; addr = 32'h40;
        step();
        start_store = 1'b0;
        chk("sbu_ill_fault", {31'h0, fault}, 32'h1);
        chk("sbu_ill_req", {31'h0, mem_req}, 32'h0);
        step();
        $display("SBU 0x40 -> illegal fault");

        // LW at 0x400 with no ack -> timeout after 16 request cycles
        start_load = 1'b1; funct3 = 3'b010; addr = 32'h400;
        step();
        start_load = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            req_cycles++;
            step();
        end
        chk("to_req_cycles", 32'(req_cycles), 32'd16);
        chk("to_done", {31'h0, done}, 32'h1);
        chk("to_fault", {31'h0, fault}, 32'h1);
        chk("to_ldata", load_data, 32'h0000_0080);
        step();
        $display("LW 0x400 no ack -> req %0d cycles, timeout fault", req_cycles);

        // Both starts high: store wins; a second load start while busy is dropped
        start_load = 1'b1; start_store = 1'b1; funct3 = 3'b010; addr = 32'h10;
        store_data = 32'hDEAD_BEEF;
        step();
        start_store = 1'b0; funct3 = 3'b000; addr = 32'h20;
        chk("both_we", {31'h0, mem_we}, 32'h1);
        chk("both_wstrb", {28'h0, mem_wstrb}, 32'hF);
        chk("both_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("both_addr", mem_addr, 32'h10);
        step();
        start_load = 1'b0;
        chk("both_addr_hold", mem_addr, 32'h10);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        done_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_count++;
            step();
        end
        chk("both_done_count", 32'(done_count), 32'd1);
        chk("both_ldata", load_data, 32'h0000_0080);
        chk("both_idle_req", {31'h0, mem_req}, 32'h0);
        $display("SW 0x10 = deadbeef with extra load start -> %0d done", done_count);

        // SH at 0x6, reset during REQ
        start_store = 1'b1; funct3 = 3'b001; addr = 32'h6; store_data = 32'h0000_1234;
        step();
        start_store = 1'b0;
        chk("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_req", {31'h0, mem_req}, 32'h0);
        chk("rstmid_busy", {31'h0, busy}, 32'h0);
        step();
        rst = 1'b0;
        chk("rstmid_done", {31'h0, done}, 32'h0);
        step();
        chk("rstmid_done2", {31'h0, done}, 32'h0);
        $display("SH 0x6 aborted by reset");

        // LHU at 0x2 after reset
        start_load = 1'b1; funct3 = 3'b101; addr = 32'h2;
        step();
        start_load = 1'b0;
        chk("lhu_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hBEEF_0000;
        step();
        mem_ack = 1'b0;
        chk("lhu_done", {31'h0, done}, 32'h1);
        chk("lhu_fault", {31'h0, fault}, 32'h0);
        chk("lhu_data", load_data, 32'h0000_BEEF);
        step();
        $display("LHU 0x2 -> load_data=%h", load_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle data-memory access unit for the RV32I core. It executes the memory phase of loads and stores on request from `control_unit` (`we_dmem` / `mux_store` / `mux_load` side). It translates byte, halfword and word accesses into word-aligned requests on a req/ack data-memory bus. It returns sign- or zero-extended load data, and signals completion or fault so the control unit can hold the PC and register file until the access resolves.

## Interface
- `TIMEOUT`, 16: maximum cycles `mem_req` is held waiting for `mem_ack` before a fault; legal range 1–255.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_load` in 1: one-cycle request to perform a load; sampled only in IDLE.
- `start_store` in 1: one-cycle request to perform a store; sampled only in IDLE; wins if asserted together with `start_load`.
- `funct3` in 3: access type: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- `addr` in 32: byte address (ALU result).
- `store_data` in 32: rs2 value.
- `busy` out 1: access in progress (REQ state).
- `done` out 1: one-cycle pulse; access finished (successfully or with fault).
- `fault` out 1: valid with `done`; 1 = misaligned, illegal `funct3`, or timeout.
- `load_data` out 32: extended load result; valid from the `done` cycle until the next load completes.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: `{addr[31:2], 2'b00}`.
- `mem_wstrb` out 4: byte-lane write enables, 0 for reads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid when `mem_ack` = 1.
- `mem_ack` in 1: bus accepts/completes the request.

## Operation
- States: IDLE, REQ, DONE. All outputs are registered.
- **IDLE**
  - On `start_store` or `start_load`, latch `funct3`, the low address bits, and the operation type.
  - Check the access:
    - misaligned if H/HU and `addr[0]` = 1, or W and `addr[1:0]` ≠ 0;
    - illegal if `funct3` ∈ {011, 110, 111}, or a store with `funct3` ∈ {100, 101}.
  - Bad access: go to DONE with `fault` = 1; no bus activity.
  - Good access: go to REQ; assert `mem_req`, `mem_we` (store only), `mem_addr`, `mem_wstrb`, `mem_wdata`; load the timeout counter with 0.
- **Store lanes**
  - SB: `wstrb` = `4'b0001 << addr[1:0]`; `wdata` = `{4{store_data[7:0]}}`.
  - SH: `wstrb` = `4'b0011 << {addr[1], 1'b0}`; `wdata` = `{2{store_data[15:0]}}`.
  - SW: `wstrb` = `4'b1111`; `wdata` = `store_data`.
- **REQ**
  - Bus outputs are held constant.
  - `mem_ack` = 1: drop `mem_req`; for loads, capture `mem_rdata` into `load_data`; go to DONE with `fault` = 0.
  - Otherwise increment the counter.
  - Counter reaching `TIMEOUT - 1` without ack: drop `mem_req`; go to DONE with `fault` = 1; `load_data` unchanged.
- **Load extract**
  - Let `s` = `mem_rdata >> (8*addr[1:0])`.
  - B: sign-extend `s[7:0]`. BU: zero-extend `s[7:0]`.
  - H: sign-extend `s[15:0]`. HU: zero-extend `s[15:0]`.
  - W: `mem_rdata`.
- **DONE**: `done` = 1 for exactly one cycle, then IDLE.
- **Ignored inputs**: starts in REQ or DONE are ignored, not queued. `mem_ack` outside REQ is ignored.

## Timing
- **Reset values**
  - State IDLE; counter 0.
  - `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wstrb`, `mem_wdata`, `load_data` = 0.
- **Reset mid-access**: asserting `rst` while in REQ drops `mem_req` immediately (asynchronous); no `done` pulse.
- **Latency**
  - Start sampled at edge N: `mem_req` = `busy` = 1 from edge N.
  - Ack sampled at edge N+k (k ≥ 1): `done` high during cycle N+k.
  - Minimum start-to-done is 2 cycles (zero-wait ack). Fault on bad access: `done` the cycle after the start edge.
- **Timeout**: `mem_req` is high for exactly `TIMEOUT` cycles, then `done` + `fault`.
- **Next start**: a new start is accepted at the edge after the `done` cycle.

## Test plan
- SB, `addr`=0x103, `store_data`=0xA5, ack after 2 wait cycles -> `mem_addr`=0x100, `wstrb`=1000, `wdata`=0xA5A5A5A5, req held 3 cycles, `done`=1, `fault`=0.
- LB then LBU, `addr`=0x202, `mem_rdata`=0x0080FF00, zero-wait ack -> `load_data`=0xFFFFFF80, then 0x00000080; `done` at start+2 cycles.
- LH at 0x201 and SW at 0x302 -> `done`+`fault` the cycle after start, `mem_req` never asserted.
- LW at 0x400 with `mem_ack` tied 0, `TIMEOUT`=16 -> `mem_req` high 16 cycles, then `done`=1, `fault`=1, `load_data` unchanged.
- `start_load` and `start_store` both high, SW 0x10 = 0xDEADBEEF -> write performed (`mem_we`=1, `wstrb`=1111); a second `start_load` while busy is ignored (exactly one `done`).
- `rst` pulsed mid-REQ of an SH -> `mem_req`, `busy` = 0 immediately; no `done`; the next LHU at 0x2 (`rdata`=0xBEEF0000) completes with `load_data`=0x0000BEEF.
